// File: rtl/glip_pattern_tester.sv
// glip_pattern_tester: device-side GLIP FIFO traffic endpoint.
// The outbound side sources an incrementing word sequence starting at SEED.
// The inbound side checks that received words follow the same sequence,
// resyncing on each mismatch, and exposes sticky status and counters.
module glip_pattern_tester #(
    parameter int unsigned       WIDTH = 16,
    parameter logic [WIDTH-1:0]  SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_en,
    input  logic             chk_en,
    input  logic             clear,
    output logic [WIDTH-1:0] fifo_out_data,
    output logic             fifo_out_valid,
    input  logic             fifo_out_ready,
    input  logic [WIDTH-1:0] fifo_in_data,
    input  logic             fifo_in_valid,
    output logic             fifo_in_ready,
    output logic             error,
    output logic [15:0]      err_count,
    output logic [31:0]      words_sent,
    output logic [31:0]      words_checked,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_received
);

    // Generator states: idle (no word offered) or presenting a word
    typedef enum logic {
        GEN_IDLE    = 1'b0,
        GEN_PRESENT = 1'b1
    } gen_state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    gen_state_t       gen_state;
    gen_state_t       gen_state_next;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_data_next;
    logic             restart;
    logic             restart_next;

    logic             out_xfer;
    logic             in_ready;
    logic             in_xfer;
    logic             mismatch;

    logic [WIDTH-1:0] expected;

    // Handshake qualifiers; inbound ready is blocked during clear so no
    // inbound word is consumed by a cycle that wipes the checker
    assign out_xfer = (gen_state == GEN_PRESENT) && fifo_out_ready;
    assign in_ready = chk_en & ~clear;
    assign in_xfer  = fifo_in_valid & in_ready;
    assign mismatch = (fifo_in_data != expected);

    assign fifo_out_valid = (gen_state == GEN_PRESENT);
    assign fifo_out_data  = out_data;
    assign fifo_in_ready  = in_ready;

    // Generator state register: offered word, valid state, restart flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_state <= GEN_IDLE;
            out_data  <= SEED;
            restart   <= 1'b0;
        end else begin
            gen_state <= gen_state_next;
            out_data  <= out_data_next;
            restart   <= restart_next;
        end
    end

    // Generator next state: a presented word is never retracted or changed
    // until accepted; a clear that lands on a pending word is remembered in
    // the restart flag so the word after the pending one becomes SEED
    always_comb begin
        gen_state_next = gen_state;
        out_data_next  = out_data;
        restart_next   = restart;
        case (gen_state)
            GEN_IDLE: begin
                if (gen_en) begin
                    gen_state_next = GEN_PRESENT;
                end
                if (clear) begin
                    out_data_next = SEED;
                    restart_next  = 1'b0;
                end
            end
            GEN_PRESENT: begin
                if (fifo_out_ready) begin
                    gen_state_next = gen_en ? GEN_PRESENT : GEN_IDLE;
                    restart_next   = 1'b0;
                    if (clear || restart) begin
                        out_data_next = SEED;
                    end else begin
                        out_data_next = out_data + ONE;
                    end
                end else if (clear) begin
                    restart_next = 1'b1;
                end
            end
            default: begin
                gen_state_next = GEN_IDLE;
            end
        endcase
    end

    // Outbound word counter; a transfer in a clear cycle is not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words_sent <= 32'd0;
        end else if (clear) begin
            words_sent <= 32'd0;
        end else if (out_xfer) begin
            words_sent <= words_sent + 32'd1;
        end
    end

    // Inbound checker: compare against the expected word, resync on a
    // mismatch, keep a sticky error, a saturating count and the first
    // mismatch pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expected      <= SEED;
            error         <= 1'b0;
            err_count     <= 16'd0;
            words_checked <= 32'd0;
            err_expected  <= '0;
            err_received  <= '0;
        end else if (clear) begin
            expected      <= SEED;
            error         <= 1'b0;
            err_count     <= 16'd0;
            words_checked <= 32'd0;
            err_expected  <= '0;
            err_received  <= '0;
        end else if (in_xfer) begin
            words_checked <= words_checked + 32'd1;
            if (mismatch) begin
                error    <= 1'b1;
                expected <= fifo_in_data + ONE;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (!error) begin
                    err_expected <= expected;
                    err_received <= fifo_in_data;
                end
            end else begin
                expected <= expected + ONE;
            end
        end
    end

endmodule

// File: tb/tb_glip_pattern_tester.sv
// Testbench for glip_pattern_tester: two instances (SEED=0 and SEED=FFFE)
// share one set of directed stimulus; a behavioural model tracks each one
// and is compared every cycle, with literal expectations at key points.
module tb_glip_pattern_tester;

    localparam logic [15:0] SEED_A = 16'h0000;
    localparam logic [15:0] SEED_B = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_en;
    logic        chk_en;
    logic        clear;
    logic        fifo_out_ready;
    logic        fifo_in_valid;
    logic [15:0] fifo_in_data;

    logic [15:0] a_out_data, b_out_data;
    logic        a_out_valid, b_out_valid;
    logic        a_in_ready, b_in_ready;
    logic        a_error, b_error;
    logic [15:0] a_err_count, b_err_count;
    logic [31:0] a_words_sent, b_words_sent;
    logic [31:0] a_words_checked, b_words_checked;
    logic [15:0] a_err_expected, b_err_expected;
    logic [15:0] a_err_received, b_err_received;

    int checks   = 0;
    int failures = 0;

    // Model state: the word on offer, the word that will follow it, the
    // next expected inbound word and the status the endpoint must report
    typedef struct packed {
        logic        ov;
        logic [15:0] od;
        logic [15:0] nxt;
        logic [15:0] exp;
        logic        err;
        logic [31:0] ec;
        logic [31:0] ws;
        logic [31:0] wc;
        logic [15:0] cap_e;
        logic [15:0] cap_r;
    } model_t;

    model_t ma;
    model_t mb;

    glip_pattern_tester #(.WIDTH(16), .SEED(SEED_A)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .gen_en         (gen_en),
        .chk_en         (chk_en),
        .clear          (clear),
        .fifo_out_data  (a_out_data),
        .fifo_out_valid (a_out_valid),
        .fifo_out_ready (fifo_out_ready),
        .fifo_in_data   (fifo_in_data),
        .fifo_in_valid  (fifo_in_valid),
        .fifo_in_ready  (a_in_ready),
        .error          (a_error),
        .err_count      (a_err_count),
        .words_sent     (a_words_sent),
        .words_checked  (a_words_checked),
        .err_expected   (a_err_expected),
        .err_received   (a_err_received)
    );

    glip_pattern_tester #(.WIDTH(16), .SEED(SEED_B)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .gen_en         (gen_en),
        .chk_en         (chk_en),
        .clear          (clear),
        .fifo_out_data  (b_out_data),
        .fifo_out_valid (b_out_valid),
        .fifo_out_ready (fifo_out_ready),
        .fifo_in_data   (fifo_in_data),
        .fifo_in_valid  (fifo_in_valid),
        .fifo_in_ready  (b_in_ready),
        .error          (b_error),
        .err_count      (b_err_count),
        .words_sent     (b_words_sent),
        .words_checked  (b_words_checked),
        .err_expected   (b_err_expected),
        .err_received   (b_err_received)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic model_t model_reset(input logic [15:0] seed);
        model_t m;
        m     = '0;
        m.od  = seed;
        m.nxt = seed + 16'd1;
        m.exp = seed;
        return m;
    endfunction

    function automatic model_t model_step(input model_t mi, input logic [15:0] seed,
                                          input logic g, input logic ce, input logic clr,
                                          input logic ordy, input logic iv,
                                          input logic [15:0] id);
        model_t m;
        m = mi;
        if (clr) begin
            m.exp   = seed;
            m.err   = 1'b0;
            m.ec    = 0;
            m.ws    = 0;
            m.wc    = 0;
            m.cap_e = 16'd0;
            m.cap_r = 16'd0;
        end else if (ce && iv) begin
            m.wc = m.wc + 1;
            if (id == m.exp) begin
                m.exp = m.exp + 16'd1;
            end else begin
                if (!m.err) begin
                    m.cap_e = m.exp;
                    m.cap_r = id;
                end
                m.err = 1'b1;
                if (m.ec < 32'd65535) m.ec = m.ec + 1;
                m.exp = id + 16'd1;
            end
        end
        if (m.ov && ordy) begin
            if (!clr) m.ws = m.ws + 1;
            if (clr) begin
                m.od  = seed;
                m.nxt = seed + 16'd1;
            end else begin
                m.od  = m.nxt;
                m.nxt = m.nxt + 16'd1;
            end
            m.ov = g;
        end else if (!m.ov) begin
            m.ov = g;
            if (clr) begin
                m.od  = seed;
                m.nxt = seed + 16'd1;
            end
        end else if (clr) begin
            m.nxt = seed;
        end
        return m;
    endfunction

    // Advance both models with the inputs sampled at each clock edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= model_reset(SEED_A);
            mb <= model_reset(SEED_B);
        end else begin
            ma <= model_step(ma, SEED_A, gen_en, chk_en, clear, fifo_out_ready,
                             fifo_in_valid, fifo_in_data);
            mb <= model_step(mb, SEED_B, gen_en, chk_en, clear, fifo_out_ready,
                             fifo_in_valid, fifo_in_data);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInstance(input string tag, input model_t m,
                                 input logic ov, input logic [15:0] od,
                                 input logic ir, input logic err,
                                 input logic [15:0] ec, input logic [31:0] ws,
                                 input logic [31:0] wc, input logic [15:0] ce,
                                 input logic [15:0] cr);
        checkOutput({tag, ".valid"}, 32'(ov), 32'(m.ov));
        if (m.ov) checkOutput({tag, ".data"}, 32'(od), 32'(m.od));
        checkOutput({tag, ".in_ready"}, 32'(ir), 32'(chk_en && !clear));
        checkOutput({tag, ".error"}, 32'(err), 32'(m.err));
        checkOutput({tag, ".err_count"}, 32'(ec), m.ec);
        checkOutput({tag, ".words_sent"}, ws, m.ws);
        checkOutput({tag, ".words_checked"}, wc, m.wc);
        checkOutput({tag, ".err_expected"}, 32'(ce), 32'(m.cap_e));
        checkOutput({tag, ".err_received"}, 32'(cr), 32'(m.cap_r));
    endtask

    // Compare both instances against their models mid-cycle
    always @(negedge clk) begin
        checkInstance("a", ma, a_out_valid, a_out_data, a_in_ready, a_error,
                      a_err_count, a_words_sent, a_words_checked,
                      a_err_expected, a_err_received);
        checkInstance("b", mb, b_out_valid, b_out_data, b_in_ready, b_error,
                      b_err_count, b_words_sent, b_words_checked,
                      b_err_expected, b_err_received);
    end

    task automatic applyStimulus(input logic g, input logic ce, input logic clr,
                                 input logic ordy, input logic iv,
                                 input logic [15:0] id);
        gen_en         = g;
        chk_en         = ce;
        clear          = clr;
        fifo_out_ready = ordy;
        fifo_in_valid  = iv;
        fifo_in_data   = id;
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence
    initial begin
        int n;
        rst            = 1'b0;
        gen_en         = 1'b0;
        chk_en         = 1'b0;
        clear          = 1'b0;
        fifo_out_ready = 1'b0;
        fifo_in_valid  = 1'b0;
        fifo_in_data   = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(a_out_valid), 32'd0);
        checkOutput("reset_data_b", 32'(b_out_data), 32'h0000FFFE);
        rst = 1'b1;

        // 1: generator free-running at one word per clock
        applyStimulus(1, 0, 0, 1, 0, 16'd0);
        checkOutput("t1_valid_rise", 32'(a_out_valid), 32'd1);
        checkOutput("t1_first_word", 32'(a_out_data), 32'd0);
        repeat (10) applyStimulus(1, 0, 0, 1, 0, 16'd0);
        checkOutput("t1_words_sent", a_words_sent, 32'd10);
        checkOutput("t1_data_a", 32'(a_out_data), 32'd10);
        checkOutput("t1_data_b_wrap", 32'(b_out_data), 32'h00000008);

        // 2: backpressure, gen_en dropped while word 5 is pending
        applyStimulus(0, 0, 0, 1, 0, 16'd0);
        applyStimulus(0, 0, 1, 1, 0, 16'd0);
        checkOutput("t2_clear_data", 32'(a_out_data), 32'd0);
        checkOutput("t2_clear_sent", a_words_sent, 32'd0);
        n = 0;
        while (!(ma.ov && ma.od == 16'd5) && n < 200) begin
            applyStimulus(1, 0, 0, 1'($urandom_range(0, 1)), 0, 16'd0);
            n++;
        end
        checkOutput("t2_reach_word5", 32'(ma.od), 32'd5);
        repeat (3) begin
            applyStimulus(0, 0, 0, 0, 0, 16'd0);
            checkOutput("t2_hold_valid", 32'(a_out_valid), 32'd1);
            checkOutput("t2_hold_data", 32'(a_out_data), 32'd5);
        end
        applyStimulus(0, 0, 0, 1, 0, 16'd0);
        checkOutput("t2_valid_drop", 32'(a_out_valid), 32'd0);
        checkOutput("t2_words_sent", a_words_sent, 32'd6);

        // 3: checker with one dropped word
        applyStimulus(0, 1, 1, 0, 0, 16'd0);
        for (int i = 0; i < 100; i++) applyStimulus(0, 1, 0, 0, 1, 16'(i));
        checkOutput("t3_no_error", 32'(a_error), 32'd0);
        checkOutput("t3_checked100", a_words_checked, 32'd100);
        applyStimulus(0, 1, 0, 0, 1, 16'd100);
        applyStimulus(0, 1, 0, 0, 1, 16'd101);
        applyStimulus(0, 1, 0, 0, 1, 16'd103);
        applyStimulus(0, 1, 0, 0, 1, 16'd104);
        applyStimulus(0, 1, 0, 0, 1, 16'd105);
        checkOutput("t3_error", 32'(a_error), 32'd1);
        checkOutput("t3_err_count", 32'(a_err_count), 32'd1);
        checkOutput("t3_err_expected", 32'(a_err_expected), 32'd102);
        checkOutput("t3_err_received", 32'(a_err_received), 32'd103);
        checkOutput("t3_checked", a_words_checked, 32'd105);

        // 5: clear while word 7 is pending
        n = 0;
        while (!(ma.ov && ma.od == 16'd7) && n < 20) begin
            applyStimulus(1, 1, 0, 1, 0, 16'd0);
            n++;
        end
        applyStimulus(1, 1, 0, 0, 0, 16'd0);
        gen_en         = 1'b1;
        chk_en         = 1'b1;
        clear          = 1'b1;
        fifo_out_ready = 1'b0;
        fifo_in_valid  = 1'b1;
        fifo_in_data   = 16'd0;
        #1;
        checkOutput("t5_in_ready_clear", 32'(a_in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t5_pending_data", 32'(a_out_data), 32'd7);
        checkOutput("t5_error_cleared", 32'(a_error), 32'd0);
        checkOutput("t5_count_cleared", 32'(a_err_count), 32'd0);
        checkOutput("t5_checked_cleared", a_words_checked, 32'd0);
        applyStimulus(1, 1, 0, 1, 0, 16'd0);
        checkOutput("t5_after_pending", 32'(a_out_data), 32'd0);
        checkOutput("t5_sent_one", a_words_sent, 32'd1);
        applyStimulus(1, 1, 0, 1, 0, 16'd0);
        checkOutput("t5_next_word", 32'(a_out_data), 32'd1);

        // 4: wrap-around on the FFFE-seeded instance, then capture hold
        applyStimulus(0, 1, 1, 1, 0, 16'd0);
        applyStimulus(0, 1, 0, 0, 1, 16'hFFFE);
        applyStimulus(0, 1, 0, 0, 1, 16'hFFFF);
        applyStimulus(0, 1, 0, 0, 1, 16'h0000);
        applyStimulus(0, 1, 0, 0, 1, 16'h0001);
        checkOutput("t4_wrap_no_error", 32'(b_error), 32'd0);
        checkOutput("t4_wrap_checked", b_words_checked, 32'd4);
        applyStimulus(0, 1, 0, 0, 1, 16'h0010);
        repeat (5) applyStimulus(0, 1, 0, 0, 1, 16'h0100);
        checkOutput("t4_b_err_count", 32'(b_err_count), 32'd6);
        checkOutput("t4_b_err_expected", 32'(b_err_expected), 32'd2);
        checkOutput("t4_b_err_received", 32'(b_err_received), 32'h10);
        checkOutput("t4_a_err_count", 32'(a_err_count), 32'd7);
        checkOutput("t4_a_err_received", 32'(a_err_received), 32'hFFFE);

        // 6: asynchronous reset mid-burst, restart, counter saturation
        repeat (3) applyStimulus(1, 1, 0, 1, 0, 16'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(a_out_valid), 32'd0);
        checkOutput("t6_async_sent", a_words_sent, 32'd0);
        checkOutput("t6_async_error", 32'(a_error), 32'd0);
        checkOutput("t6_async_data_b", 32'(b_out_data), 32'h0000FFFE);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1, 1, 0, 1, 0, 16'd0);
        checkOutput("t6_restart_data", 32'(a_out_data), 32'd0);
        applyStimulus(0, 1, 0, 1, 0, 16'd0);
        checkOutput("t6_restart_next", 32'(a_words_sent), 32'd1);
        repeat (65540) applyStimulus(0, 1, 0, 0, 1, 16'h1234);
        checkOutput("t6_saturated", 32'(a_err_count), 32'h0000FFFF);
        checkOutput("t6_checked", a_words_checked, 32'd65540);
        checkOutput("t6_cap_expected", 32'(a_err_expected), 32'd0);
        checkOutput("t6_cap_received", 32'(a_err_received), 32'h1234);
        checkOutput("t6_cap_expected_b", 32'(b_err_expected), 32'hFFFE);

        applyStimulus(0, 0, 0, 0, 0, 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
